icache_dm: RTL
==============

// Module: icache_dm
// PURPOSE
//  Direct-mapped, read-only instruction cache between the pipeline fetch port and the memory controller.
//  Consumes datapath imemREN/imemaddr and returns ihit/imemload, which feed the IFID latch.
//  On a miss it issues a single-word read to memory, fills the frame, then hits on the next cycle.
//  One word per block; no writes, no coherence.
// PARAMETERS
//  NSETS   16  number of frames; power of 2, >=2; IDXW = $clog2(NSETS)
//  (word 32 bits; byte offset [1:0] ignored; index = addr[IDXW+1:2]; tag = addr[31:IDXW+2], 26 bits at default)
// PORTS
//  CLK        in   1   clock, rising edge
//  nRST       in   1   asynchronous reset, active-low
//  imemREN    in   1   datapath instruction read request
//  imemaddr   in   32  datapath fetch address (PC)
//  ihit       out  1   requested word valid on imemload this cycle
//  imemload   out  32  instruction word
//  iREN       out  1   read request to memory controller
//  iaddr      out  32  memory read address (word aligned, [1:0]=0)
//  iwait      in   1   memory busy; iload valid in the cycle iREN=1 and iwait=0
//  iload      in   32  memory read data
//  hit_count  out  32  (ICACHE_STATS_EN only) completed hits
//  miss_count out  32  (ICACHE_STATS_EN only) misses started
// BEHAVIOUR
//  Storage: per frame valid(1), tag(TAGW), data(32); all valid bits cleared by nRST; tag/data not reset.
//  FSM: IDLE, FETCH; reset state IDLE.
//  IDLE: hit = imemREN & valid[idx] & (tag[idx]==addr tag); ihit=hit, imemload=data[idx] (combinational, 0-cycle).
//    imemREN & !hit -> latch miss_addr = {imemaddr[31:2],2'b00}; next FETCH. Miss not flagged as ihit.
//    imemREN=0 -> ihit=0, no state change.
//  FETCH: iREN=1, iaddr=miss_addr; ihit=0.
//    iwait=1 -> stay. iwait=0 -> write valid=1, tag, data=iload into frame of miss_addr; next IDLE.
//    Changes of imemaddr/imemREN during FETCH are ignored; fill always completes to miss_addr.
//    After fill, IDLE re-evaluates the current imemaddr (hits if unchanged).
//  Outputs when not hitting: imemload=32'h0. iREN=0 and iaddr=32'h0 outside FETCH.
//  Latency: hit 0 cycles; miss = 1 (IDLE->FETCH) + memory wait cycles + 1 (fill->hit).
//  Conflict: a fill overwrites the existing frame unconditionally (no victim handling).
//  Reset mid-FETCH: abort; no frame written; IDLE, iREN=0 immediately (async).
//  Reset values: ihit=0, imemload=0, iREN=0, iaddr=0, state IDLE, counters 0.
// CONFIGURATION
//  ICACHE_STATS_EN defined: hit_count increments on every cycle with ihit=1; miss_count increments
//    on every IDLE->FETCH transition; both saturate at 32'hFFFF_FFFF; cleared only by nRST.
//  Not defined: hit_count/miss_count ports and counter logic absent; all other behaviour identical.
// TESTING
//  1 Reset, imemREN=1, imemaddr=0x0000_0000 -> ihit=0; next cycle iREN=1, iaddr=0x0; iwait=0,
//    iload=0x2001_0005 -> next cycle ihit=1, imemload=0x2001_0005.
//  2 After T1, imemaddr=0x0000_0002 (same word) -> ihit=1 same cycle, imemload=0x2001_0005, iREN=0.
//  3 NSETS=16: fill 0x0000_0004 (data 0xAAAA_AAAA), then 0x0000_0044 (same index 1, data 0xBBBB_BBBB)
//    -> 0x44 hits 0xBBBB_BBBB; re-access 0x04 misses, iaddr=0x04.
//  4 Miss on 0x100 with iwait=1 for 5 cycles; change imemaddr to 0x200 mid-fetch -> iaddr held 0x100,
//    frame 0x100 filled, then IDLE misses on 0x200 (iaddr=0x200).
//  5 Assert nRST=0 during FETCH of 0x300 -> iREN=0 immediately; after release, 0x300 misses again.
//  6 ICACHE_STATS_EN: run T1 then 3 hit cycles -> miss_count=1, hit_count=4; without macro,
//    build has no counter ports and T1-T5 pass unchanged.

Source files
------------

// File: rtl/icache_dm_if.sv
// icache_dm_if: fetch-side and memory-side signals of the direct-mapped instruction cache.
// master = pipeline/memory environment, slave = cache.
interface icache_dm_if;
  logic        imemren;
  logic [31:0] imemaddr;
  logic        ihit;
  logic [31:0] imemload;
  logic        iren;
  logic [31:0] iaddr;
  logic        iwait;
  logic [31:0] iload;

  modport master (
    output imemren, imemaddr, iwait, iload,
    input  ihit, imemload, iren, iaddr
  );

  modport slave (
    input  imemren, imemaddr, iwait, iload,
    output ihit, imemload, iren, iaddr
  );
endinterface

// File: rtl/icache_dm.sv
// icache_dm: direct-mapped, read-only instruction cache, one 32-bit word per frame.
// Optional build macro ICACHE_STATS_EN adds saturating hit_count/miss_count ports.
module icache_dm #(
  parameter int unsigned NSETS = 16
) (
  input  logic        clk,
  input  logic        rst_n,
  icache_dm_if.slave  bus
`ifdef ICACHE_STATS_EN
  ,
  output logic [31:0] hit_count,
  output logic [31:0] miss_count
`endif
);
  localparam int unsigned IDXW  = $clog2(NSETS);
  localparam int unsigned TAGW  = 32 - IDXW - 2;
  localparam int unsigned WORDW = 32;

  localparam logic [0:0] IDLE  = 1'b0;
  localparam logic [0:0] FETCH = 1'b1;

  logic [0:0]       state;
  logic [0:0]       state_nxt;
  logic [NSETS-1:0] valid;
  logic [TAGW-1:0]  tags  [NSETS];
  logic [WORDW-1:0] words [NSETS];
  logic [31:0]      miss_addr;

  logic [IDXW-1:0]  req_idx;
  logic [TAGW-1:0]  req_tag;
  logic [IDXW-1:0]  fill_idx;
  logic [TAGW-1:0]  fill_tag;
  logic             lookup_hit;
  logic             miss_start;
  logic             fill;
  logic             unused_addr_lsbs;

  // Byte offset never selects anything: the cache returns whole words.
  assign unused_addr_lsbs = ^bus.imemaddr[1:0];

  assign req_idx  = bus.imemaddr[IDXW+1:2];
  assign req_tag  = bus.imemaddr[31:IDXW+2];
  assign fill_idx = miss_addr[IDXW+1:2];
  assign fill_tag = miss_addr[31:IDXW+2];

  assign lookup_hit = bus.imemren & valid[req_idx] & (tags[req_idx] == req_tag);

  // Next state and outputs; hits are answered in the same cycle they are requested.
  always_comb begin
    state_nxt    = state;
    miss_start   = 1'b0;
    fill         = 1'b0;
    bus.ihit     = 1'b0;
    bus.imemload = '0;
    bus.iren     = 1'b0;
    bus.iaddr    = '0;
    case (state)
      IDLE: begin
        if (lookup_hit) begin
          bus.ihit     = 1'b1;
          bus.imemload = words[req_idx];
        end else if (bus.imemren) begin
          miss_start = 1'b1;
          state_nxt  = FETCH;
        end
      end
      FETCH: begin
        bus.iren  = 1'b1;
        bus.iaddr = miss_addr;
        if (!bus.iwait) begin
          fill      = 1'b1;
          state_nxt = IDLE;
        end
      end
      default: state_nxt = IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state <= IDLE;
    end else begin
      state <= state_nxt;
    end
  end

  // The miss address is frozen for the whole fetch; later PC changes are ignored.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      miss_addr <= '0;
    end else if (miss_start) begin
      miss_addr <= {bus.imemaddr[31:2], 2'b00};
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      valid <= '0;
    end else if (fill) begin
      valid[fill_idx] <= 1'b1;
    end
  end

  // Tag and data arrays carry no reset; the valid bits qualify them.
  always_ff @(posedge clk) begin
    if (fill) begin
      tags[fill_idx]  <= fill_tag;
      words[fill_idx] <= bus.iload;
    end
  end

`ifdef ICACHE_STATS_EN
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      hit_count  <= '0;
      miss_count <= '0;
    end else begin
      if (lookup_hit && (state == IDLE) && (hit_count != 32'hFFFF_FFFF)) begin
        hit_count <= hit_count + 32'd1;
      end
      if (miss_start && (miss_count != 32'hFFFF_FFFF)) begin
        miss_count <= miss_count + 32'd1;
      end
    end
  end
`endif

endmodule
